// File: rtl/ecc_csr_if.sv
// Host APB bus for the ECC CSR block: master drives the request, slave returns
// read data, ready and error.
interface ecc_csr_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 10
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [REG_ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0]     pwdata;
    logic [3:0]                pstrb;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ecc_csr.sv
// ECC control/status registers: captures detector SEC/DED events into sticky
// bits and saturating counters, drives enables back, and serves a host APB port.
module ecc_csr #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_psel,
    input  logic                      i_penable,
    input  logic                      i_pwrite,
    input  logic [REG_ADDR_WIDTH-1:0] i_paddr,
    input  logic [3:0]                i_pstrb,
    input  logic [DATA_WIDTH-1:0]     error_type,
    ecc_csr_if.slave                  host,
    output logic [DATA_WIDTH-1:0]     ECC_en,
    output logic [DATA_WIDTH-1:0]     ECC_irq_en,
    output logic                      ecc_irq
);

    localparam logic [REG_ADDR_WIDTH-1:0] AddrStatus = REG_ADDR_WIDTH'('h000);
    localparam logic [REG_ADDR_WIDTH-1:0] AddrEn     = REG_ADDR_WIDTH'('h004);
    localparam logic [REG_ADDR_WIDTH-1:0] AddrIrqEn  = REG_ADDR_WIDTH'('h008);
    localparam logic [REG_ADDR_WIDTH-1:0] AddrSecCnt = REG_ADDR_WIDTH'('h00C);
    localparam logic [REG_ADDR_WIDTH-1:0] AddrDedCnt = REG_ADDR_WIDTH'('h010);
    localparam logic [CNT_WIDTH-1:0]      CntMax     = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StSetup, StWait, StResp} state_e;

    state_e                    state_q, state_d;
    logic                      sec_q, sec_d;
    logic                      ded_q, ded_d;
    logic [1:0]                last_q, last_d;
    logic [CNT_WIDTH-1:0]      sec_cnt_q, sec_cnt_d;
    logic [CNT_WIDTH-1:0]      ded_cnt_q, ded_cnt_d;
    logic [DATA_WIDTH-1:0]     en_q, en_d;
    logic [DATA_WIDTH-1:0]     irq_en_q, irq_en_d;
    logic                      irq_q;
    logic [DATA_WIDTH-1:0]     prdata_q;
    logic                      pslverr_q;
    logic                      wr_pend_q;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;
    logic [3:0]                wr_strb_q;

    logic                      load_resp;
    logic                      addr_ok;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      commit;
    logic                      det_ev, det_sec, det_ded;
    logic                      unused_det_strb;

    // Detector byte strobes carry no meaning for status events.
    assign unused_det_strb = ^i_pstrb;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [3:0]            strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Host FSM
    always_comb begin
        state_d   = state_q;
        load_resp = 1'b0;
        case (state_q)
            StIdle:  if (host.psel && !host.penable) state_d = StSetup;
            StSetup: begin
                if (!host.psel)        state_d = StIdle;
                else if (host.penable) state_d = StWait;
            end
            StWait: begin
                if (!host.psel) begin
                    state_d = StIdle;
                end else begin
                    state_d   = StResp;
                    load_resp = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read mux; an exact-match decode also rejects misaligned addresses.
    always_comb begin
        addr_ok = 1'b1;
        rd_data = '0;
        case (host.paddr)
            AddrStatus: rd_data = DATA_WIDTH'({last_q, ded_q, sec_q});
            AddrEn:     rd_data = en_q;
            AddrIrqEn:  rd_data = irq_en_q;
            AddrSecCnt: rd_data = DATA_WIDTH'(sec_cnt_q);
            AddrDedCnt: rd_data = DATA_WIDTH'(ded_cnt_q);
            default:    addr_ok = 1'b0;
        endcase
    end

    assign commit  = (state_q == StResp) && wr_pend_q;
    assign det_ev  = i_psel && i_penable && i_pwrite && (i_paddr == '0);
    assign det_sec = det_ev && (error_type == DATA_WIDTH'(1));
    assign det_ded = det_ev && (error_type == DATA_WIDTH'(2));

    // Host clears are applied first so a same-edge detector event wins.
    always_comb begin
        sec_d     = sec_q;
        ded_d     = ded_q;
        last_d    = last_q;
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        en_d      = en_q;
        irq_en_d  = irq_en_q;

        if (commit) begin
            case (wr_addr_q)
                AddrStatus: begin
                    if (wr_strb_q[0] && wr_data_q[0]) sec_d = 1'b0;
                    if (wr_strb_q[0] && wr_data_q[1]) ded_d = 1'b0;
                end
                AddrEn:     en_d      = merge_lanes(en_q, wr_data_q, wr_strb_q);
                AddrIrqEn:  irq_en_d  = merge_lanes(irq_en_q, wr_data_q, wr_strb_q);
                AddrSecCnt: sec_cnt_d = '0;
                AddrDedCnt: ded_cnt_d = '0;
                default:    ;
            endcase
        end

        if (det_sec) begin
            sec_d  = 1'b1;
            last_d = 2'd1;
            if (sec_cnt_d != CntMax) sec_cnt_d = sec_cnt_d + CNT_WIDTH'(1);
        end
        if (det_ded) begin
            ded_d  = 1'b1;
            last_d = 2'd2;
            if (ded_cnt_d != CntMax) ded_cnt_d = ded_cnt_d + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sec_q     <= 1'b0;
            ded_q     <= 1'b0;
            last_q    <= 2'd0;
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
            en_q      <= DATA_WIDTH'(1);
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            ded_q     <= ded_d;
            last_q    <= last_d;
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= ded_d && irq_en_d[0];
            if (load_resp) begin
                prdata_q  <= rd_data;
                pslverr_q <= !addr_ok;
                wr_pend_q <= host.pwrite && addr_ok;
                wr_addr_q <= host.paddr;
                wr_data_q <= host.pwdata;
                wr_strb_q <= host.pstrb;
            end else if (state_q == StResp) begin
                prdata_q  <= '0;
                pslverr_q <= 1'b0;
                wr_pend_q <= 1'b0;
            end
        end
    end

    assign host.prdata  = prdata_q;
    assign host.pslverr = pslverr_q;
    assign host.pready  = (state_q == StResp);
    assign ECC_en       = en_q;
    assign ECC_irq_en   = irq_en_q;
    assign ecc_irq      = irq_q;

endmodule

// File: tb/tb_ecc_csr.sv
// Bench for ecc_csr: directed steps plus random traffic checked against a
// register-level model of the CSR map.
module tb_ecc_csr;

    localparam int unsigned CntMax = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_psel = 1'b0, i_penable = 1'b0, i_pwrite = 1'b0;
    logic [9:0]  i_paddr = '0;
    logic [3:0]  i_pstrb = '0;
    logic [31:0] error_type = '0;
    logic [31:0] ECC_en, ECC_irq_en;
    logic        ecc_irq;

    int n_checks = 0;
    int n_err = 0;

    // Model state
    int unsigned m_sec_cnt, m_ded_cnt;
    bit          m_sec, m_ded;
    bit [1:0]    m_last;
    bit [31:0]   m_en, m_irq_en;

    ecc_csr_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(10)) bus ();

    ecc_csr #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_psel     (i_psel),
        .i_penable  (i_penable),
        .i_pwrite   (i_pwrite),
        .i_paddr    (i_paddr),
        .i_pstrb    (i_pstrb),
        .error_type (error_type),
        .host       (bus),
        .ECC_en     (ECC_en),
        .ECC_irq_en (ECC_irq_en),
        .ecc_irq    (ecc_irq)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_sec_cnt = 0; m_ded_cnt = 0; m_sec = 0; m_ded = 0; m_last = 0;
        m_en = 32'h1; m_irq_en = 0;
    endfunction

    function automatic bit mapped(input bit [9:0] a);
        return (a % 4 == 0) && (a <= 10'h010);
    endfunction

    function automatic bit [31:0] model_read(input bit [9:0] a);
        case (a)
            10'h000: return 32'(m_sec) + 32'(m_ded) * 2 + 32'(m_last) * 4;
            10'h004: return m_en;
            10'h008: return m_irq_en;
            10'h00C: return m_sec_cnt;
            10'h010: return m_ded_cnt;
            default: return 0;
        endcase
    endfunction

    function automatic void model_write(input bit [9:0] a, input bit [31:0] d, input bit [3:0] s);
        case (a)
            10'h000: if (s[0]) begin
                if (d[0]) m_sec = 0;
                if (d[1]) m_ded = 0;
            end
            10'h004: for (int b = 0; b < 4; b++) if (s[b]) m_en[8*b +: 8] = d[8*b +: 8];
            10'h008: for (int b = 0; b < 4; b++) if (s[b]) m_irq_en[8*b +: 8] = d[8*b +: 8];
            10'h00C: m_sec_cnt = 0;
            10'h010: m_ded_cnt = 0;
            default: ;
        endcase
    endfunction

    function automatic void model_event(input bit [31:0] et);
        if (et == 1) begin
            m_sec = 1; m_last = 1;
            if (m_sec_cnt < CntMax) m_sec_cnt++;
        end else if (et == 2) begin
            m_ded = 1; m_last = 2;
            if (m_ded_cnt < CntMax) m_ded_cnt++;
        end
    endfunction

    function automatic bit model_irq();
        return m_ded && m_irq_en[0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Detector drive: all tasks start and end just after a rising edge.
    task automatic det_cycle(input bit [31:0] et, input bit s, input bit e, input bit w,
                             input bit [9:0] a);
        i_psel = s; i_penable = e; i_pwrite = w; i_paddr = a; error_type = et;
        i_pstrb = 4'($urandom);
        @(posedge clk); #1;
        if (s && e && w && a == 0) model_event(et);
        i_psel = 0; i_penable = 0; i_pwrite = 0; i_paddr = 0; error_type = 0;
    endtask

    task automatic apb_xfer(input bit wr, input bit [9:0] a, input bit [31:0] wd,
                            input bit [3:0] s, input int co_et,
                            output logic [31:0] rd, output logic err, output int lat);
        bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a;
        bus.pwdata = wd; bus.pstrb = s;
        @(posedge clk); #1;
        bus.penable = 1;
        lat = 1;
        while (bus.pready !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("pready_seen", 32'(bus.pready), 32'd1);
        rd = bus.prdata;
        err = bus.pslverr;
        if (co_et >= 0) begin
            i_psel = 1; i_penable = 1; i_pwrite = 1; i_paddr = 0; error_type = co_et;
        end
        @(posedge clk); #1;
        if (wr) model_write(a, wd, s);
        if (co_et >= 0) model_event(co_et);
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
        i_psel = 0; i_penable = 0; i_pwrite = 0; error_type = 0;
    endtask

    task automatic rd_chk(input bit [9:0] a, input string tag);
        logic [31:0] rd; logic err; int lat; bit [31:0] exp;
        exp = model_read(a);
        apb_xfer(0, a, 32'($urandom), 4'hF, -1, rd, err, lat);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_err"}, 32'(err), 32'(!mapped(a)));
    endtask

    task automatic wr_chk(input bit [9:0] a, input bit [31:0] d, input bit [3:0] s,
                          input int co_et, input string tag);
        logic [31:0] rd; logic err; int lat;
        apb_xfer(1, a, d, s, co_et, rd, err, lat);
        chk({tag, "_err"}, 32'(err), 32'(!mapped(a)));
    endtask

    initial begin
        logic [31:0] rd; logic err; int lat;
        bit [9:0] addr_tab [8];
        addr_tab = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h014, 10'h002, 10'h020};
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0;
        bus.pwdata = 0; bus.pstrb = 0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ecc_en", ECC_en, 32'h1);
        chk("rst_irq_en", ECC_irq_en, 32'h0);
        chk("rst_irq", 32'(ecc_irq), 32'h0);
        chk("rst_pready", 32'(bus.pready), 32'h0);
        chk("rst_pslverr", 32'(bus.pslverr), 32'h0);
        chk("rst_prdata", bus.prdata, 32'h0);
        rst_n = 1;
        @(posedge clk); #1;
        apb_xfer(0, 10'h004, 0, 4'hF, -1, rd, err, lat);
        chk("rst_read_en", rd, 32'h1);
        chk("read_latency", 32'(lat), 32'd3);
        rd_chk(10'h000, "rst_status");
        rd_chk(10'h00C, "rst_sec_cnt");
        rd_chk(10'h010, "rst_ded_cnt");

        // Five back-to-back SEC events
        for (int i = 0; i < 5; i++) det_cycle(1, 1, 1, 1, 0);
        chk("sec5_irq", 32'(ecc_irq), 32'h0);
        apb_xfer(0, 10'h00C, 0, 4'hF, -1, rd, err, lat);
        chk("sec5_cnt", rd, 32'd5);
        apb_xfer(0, 10'h000, 0, 4'hF, -1, rd, err, lat);
        chk("sec5_status", rd, 32'h5);

        // DED with interrupt enabled, then W1C
        wr_chk(10'h008, 32'h1, 4'hF, -1, "wr_irq_en");
        chk("irq_en_out", ECC_irq_en, 32'h1);
        det_cycle(2, 1, 1, 1, 0);
        chk("ded_irq", 32'(ecc_irq), 32'h1);
        apb_xfer(0, 10'h000, 0, 4'hF, -1, rd, err, lat);
        chk("ded_status", rd, 32'hB);
        wr_chk(10'h000, 32'h2, 4'h1, -1, "w1c_ded");
        chk("w1c_ded_irq", 32'(ecc_irq), 32'h0);
        rd_chk(10'h000, "w1c_ded_status");

        // Same-edge W1C vs set, clear vs increment
        wr_chk(10'h000, 32'h1, 4'h1, 1, "w1c_sec_race");
        apb_xfer(0, 10'h000, 0, 4'hF, -1, rd, err, lat);
        chk("race_sec_sticky", rd & 32'h1, 32'h1);
        wr_chk(10'h00C, 32'h0, 4'h0, 1, "clr_cnt_race");
        apb_xfer(0, 10'h00C, 0, 4'hF, -1, rd, err, lat);
        chk("race_cnt", rd, 32'd1);

        // Disabling the interrupt keeps DED latched
        det_cycle(2, 1, 1, 1, 0);
        chk("ded2_irq", 32'(ecc_irq), 32'h1);
        wr_chk(10'h008, 32'h0, 4'h1, -1, "irq_dis");
        chk("irq_dis_irq", 32'(ecc_irq), 32'h0);
        apb_xfer(0, 10'h000, 0, 4'hF, -1, rd, err, lat);
        chk("irq_dis_ded_kept", rd & 32'h2, 32'h2);

        // Byte-lane write and bad addresses
        wr_chk(10'h004, 32'hFFFF_FF00, 4'b0010, -1, "lane_wr");
        chk("lane_ecc_en", ECC_en, 32'h0000_FF01);
        apb_xfer(0, 10'h020, 0, 4'hF, -1, rd, err, lat);
        chk("unmapped_err", 32'(err), 32'h1);
        chk("unmapped_data", rd, 32'h0);
        rd_chk(10'h002, "misaligned");
        wr_chk(10'h006, 32'hFFFF_FFFF, 4'hF, -1, "misaligned_wr");
        chk("misaligned_wr_no_eff", ECC_en, m_en);

        // Host abandons the transfer in WAIT
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 10'h008;
        bus.pwdata = 32'hFFFF_FFFF; bus.pstrb = 4'hF;
        @(posedge clk); #1; bus.penable = 1;
        @(posedge clk); #1; bus.psel = 0; bus.penable = 0;
        @(posedge clk); #1;
        chk("abort_pready", 32'(bus.pready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_irq_en", ECC_irq_en, m_irq_en);

        // Reset mid-write
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 10'h004;
        bus.pwdata = 32'h1234_5678; bus.pstrb = 4'hF;
        @(posedge clk); #1; bus.penable = 1;
        @(posedge clk); #1; rst_n = 0;
        #1;
        model_reset();
        chk("midrst_ecc_en", ECC_en, 32'h1);
        chk("midrst_irq", 32'(ecc_irq), 32'h0);
        chk("midrst_pready", 32'(bus.pready), 32'h0);
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;
        rd_chk(10'h004, "midrst_en_read");
        rd_chk(10'h000, "midrst_status");

        // Counter saturation
        for (int i = 0; i < 65536; i++) det_cycle(1, 1, 1, 1, 0);
        apb_xfer(0, 10'h00C, 0, 4'hF, -1, rd, err, lat);
        chk("sat_cnt", rd, 32'h0000_FFFF);

        // Random traffic
        for (int it = 0; it < 80; it++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op == 0) begin
                int n;
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    bit [31:0] et;
                    et = ($urandom_range(0, 4) == 4) ? 32'($urandom) : 32'($urandom_range(0, 3));
                    det_cycle(et, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                              $urandom_range(0, 7) != 0,
                              ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h0);
                end
            end else if (op == 1) begin
                int co;
                co = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
                wr_chk(addr_tab[$urandom_range(0, 7)], 32'($urandom), 4'($urandom), co, "rnd_wr");
            end else if (op == 2) begin
                rd_chk(addr_tab[$urandom_range(0, 7)], "rnd_rd");
            end else begin
                chk("rnd_ecc_en", ECC_en, m_en);
                chk("rnd_irq_en", ECC_irq_en, m_irq_en);
            end
            chk("rnd_irq", 32'(ecc_irq), 32'(model_irq()));
        end
        for (int a = 0; a <= 16; a += 4) rd_chk(10'(a), "final_rd");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
